bfp16_ws_weight_loader: RTL and testbench
=========================================

Name: bfp16_ws_weight_loader

Overview:
- Column sequencer that sits directly upstream of one column of ROWS cascaded BFP16 weight-stationary PEs.
- Collects ROWS weights through a valid/ready handshake and bursts them down the column with pe_ctrl=0, deepest PE first.
- Then holds pe_ctrl=1 and seeds zero psum for a programmed compute length, followed by a psum drain window.
- The weight chain cannot stall; every ctrl=0 cycle shifts the column. All weights are therefore buffered before the burst starts.

Parameters:
- ROWS, 4, number of PEs in the driven column (≥2).
- CNT_W, 16, width of the compute-length counter and cmp_len.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- w_valid  in  1  weight word valid
- w_ready  out  1  loader can accept weight word
- w_data  in  16  BFP16 weight; first accepted word targets row 0 (top PE)
- cmp_len  in  CNT_W  compute cycles; sampled on the cycle the final weight of a set is accepted
- pe_ctrl  out  1  column ctrl (1 = HOLD/compute, 0 = weight shift)
- pe_in  out  16  column top input (weight during BURST, psum seed 0 otherwise)
- ifmap_en  out  1  tells the ifmap feeder to inject a row this cycle
- busy  out  1  set is being loaded or executed
- done  out  1  one-cycle pulse at end of drain

Behaviour:
- States: FILL (reset state), BURST, COMPUTE, DRAIN. Outputs are decoded from registered state, counters and buffer. No combinational path runs from w_valid to any output except w_ready.
- Reset values: state=FILL, fill_cnt=0, all counters 0, pe_ctrl=0, pe_in=0, ifmap_en=0, done=0, busy=0, w_ready=1 on the first post-reset cycle.
- FILL:
  - w_ready=1; pe_ctrl=0; pe_in=0.
  - On w_valid&w_ready, write buf[fill_cnt]=w_data and increment fill_cnt.
  - On the handshake that makes fill_cnt==ROWS: latch cmp_len and go to BURST next cycle. w_ready is 0 from that next cycle on.
- BURST: exactly ROWS cycles. Cycle k (0..ROWS-1): pe_ctrl=0, pe_in=buf[ROWS-1-k]. After the last cycle, row r's PE holds buf[r].
- COMPUTE:
  - Entered after BURST when latched len≠0; lasts exactly len cycles.
  - pe_ctrl=1, pe_in=16'h0000, ifmap_en=1.
  - len==0 skips COMPUTE and goes directly to DRAIN.
- DRAIN: exactly ROWS cycles. pe_ctrl=1, pe_in=0, ifmap_en=0, so the last psum exits the column bottom.
- After DRAIN: return to FILL, fill_cnt=0. done=1 for exactly the first cycle back in FILL.
- busy = (state≠FILL) | (fill_cnt≠0).
- Counters:
  - The phase counter is clog2(ROWS)+1 bits and wraps to 0 on every state change.
  - The compute counter is CNT_W bits and counts down. cmp_len = 2^CNT_W-1 is legal and must not overflow.
- w_valid is ignored whenever w_ready=0; w_data is never written in that case.
- Reset asserted mid-burst or mid-compute aborts immediately to reset values. Partially filled buffer contents are discarded (fill_cnt=0). No done pulse is produced.

Optional Feature:
- Macro WL_PREFETCH_EN.
- Defined:
  - Adds a second ROWS×16 shadow buffer.
  - w_ready=1 in COMPUTE and DRAIN while the shadow is not full; accepted words fill the shadow in row order and the shadow latches its own cmp_len.
  - On DRAIN exit with the shadow full: buffers swap, done pulses, and state goes directly to BURST with no FILL cycle. busy stays 1.
  - On DRAIN exit with the shadow partially filled: enter FILL with fill_cnt equal to the shadow count, continuing that set.
- Undefined: single buffer; w_ready=0 in every state except FILL.

Test Plan (ROWS=4, CNT_W=16):
- Reset release, w_valid=0 for 10 cycles -> w_ready=1, busy=0, pe_ctrl=0, pe_in=0, done=0 throughout.
- Load 3F80,4000,4040,4080 back-to-back, cmp_len=5 -> pe_in=4080,4040,4000,3F80 over 4 cycles with pe_ctrl=0. Then pe_ctrl=1 and ifmap_en=1 for 5 cycles, then 4 drain cycles. done pulses once, 14 cycles after the last accept.
- Same load with w_valid gapped (1 cycle on, 2 off) -> identical BURST sequence with no bubbles. w_ready drops the cycle after the 4th accept.
- cmp_len=0 -> ifmap_en never asserts; DRAIN follows BURST directly; done pulses 9 cycles after the last accept.
- rst asserted in COMPUTE cycle 2 -> next cycle all outputs at reset values. A new 4-word load then bursts only the new words.
- WL_PREFETCH_EN, second set offered during COMPUTE -> accepted while pe_ctrl=1. After done, BURST starts with no FILL cycle, and busy stays 1.

Source files
------------

// File: rtl/bfp16_ws_weight_loader.sv
// Column sequencer for a weight-stationary BFP16 PE column: buffer ROWS weights, burst them deepest-first, then compute and drain.
// Optional WL_PREFETCH_EN adds a shadow buffer that loads the next set during COMPUTE/DRAIN.
module bfp16_ws_weight_loader #(
    parameter int unsigned ROWS  = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             w_valid,
    output logic             w_ready,
    input  logic [15:0]      w_data,
    input  logic [CNT_W-1:0] cmp_len,
    output logic             pe_ctrl,
    output logic [15:0]      pe_in,
    output logic             ifmap_en,
    output logic             busy,
    output logic             done
);
    localparam int unsigned PH_W = $clog2(ROWS) + 1;
    localparam logic [PH_W-1:0] LAST_PH = PH_W'(ROWS - 1);

    localparam logic [1:0] S_FILL    = 2'd0;
    localparam logic [1:0] S_BURST   = 2'd1;
    localparam logic [1:0] S_COMPUTE = 2'd2;
    localparam logic [1:0] S_DRAIN   = 2'd3;

    logic [1:0]       state_q, state_nx;
    logic [PH_W-1:0]  phase_q, phase_nx;
    logic [PH_W-1:0]  fill_q, fill_nx;
    logic [CNT_W-1:0] cmp_q, cmp_nx;
    logic             done_q, done_nx;
    logic [15:0]      wbuf_q [ROWS];
    logic [15:0]      wbuf_nx [ROWS];
    logic [15:0]      burst_word;
    logic             pf_rdy;
    logic             accept;

`ifdef WL_PREFETCH_EN
    localparam logic [PH_W-1:0] FULL = PH_W'(ROWS);
    logic [15:0]      sbuf_q [ROWS];
    logic [15:0]      sbuf_nx [ROWS];
    logic [PH_W-1:0]  sfill_q, sfill_nx;
    logic [CNT_W-1:0] slen_q, slen_nx;

    assign pf_rdy = ((state_q == S_COMPUTE) || (state_q == S_DRAIN)) && (sfill_q != FULL);
`else
    assign pf_rdy = 1'b0;
`endif

    // Output decode from registered state only; w_valid never reaches an output.
    assign w_ready  = (state_q == S_FILL) | pf_rdy;
    assign accept   = w_valid & w_ready;
    assign pe_ctrl  = (state_q == S_COMPUTE) || (state_q == S_DRAIN);
    assign ifmap_en = (state_q == S_COMPUTE);
    assign pe_in    = (state_q == S_BURST) ? burst_word : 16'h0000;
    assign busy     = (state_q != S_FILL) || (fill_q != '0);
    assign done     = done_q;

    // Burst cycle k presents buf[ROWS-1-k] so the deepest PE gets its weight first.
    always_comb begin
        burst_word = 16'h0000;
        for (int unsigned i = 0; i < ROWS; i++) begin
            if (phase_q == PH_W'(ROWS - 1 - i)) burst_word = wbuf_q[i];
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_nx = state_q;
        phase_nx = phase_q;
        fill_nx  = fill_q;
        cmp_nx   = cmp_q;
        done_nx  = 1'b0;
        wbuf_nx  = wbuf_q;
`ifdef WL_PREFETCH_EN
        sbuf_nx  = sbuf_q;
        sfill_nx = sfill_q;
        slen_nx  = slen_q;
        if (accept && (state_q != S_FILL)) begin
            for (int unsigned i = 0; i < ROWS; i++) begin
                if (sfill_q == PH_W'(i)) sbuf_nx[i] = w_data;
            end
            sfill_nx = sfill_q + PH_W'(1);
            if (sfill_q == LAST_PH) slen_nx = cmp_len;
        end
`endif
        case (state_q)
            S_FILL: begin
                if (accept) begin
                    for (int unsigned i = 0; i < ROWS; i++) begin
                        if (fill_q == PH_W'(i)) wbuf_nx[i] = w_data;
                    end
                    if (fill_q == LAST_PH) begin
                        fill_nx  = '0;
                        cmp_nx   = cmp_len;
                        phase_nx = '0;
                        state_nx = S_BURST;
                    end else begin
                        fill_nx = fill_q + PH_W'(1);
                    end
                end
            end
            S_BURST: begin
                if (phase_q == LAST_PH) begin
                    phase_nx = '0;
                    state_nx = (cmp_q == '0) ? S_DRAIN : S_COMPUTE;
                end else begin
                    phase_nx = phase_q + PH_W'(1);
                end
            end
            S_COMPUTE: begin
                // Count down from len and leave on 1, so an all-ones length never wraps.
                if (cmp_q == CNT_W'(1)) begin
                    cmp_nx   = '0;
                    phase_nx = '0;
                    state_nx = S_DRAIN;
                end else begin
                    cmp_nx = cmp_q - CNT_W'(1);
                end
            end
            S_DRAIN: begin
                if (phase_q == LAST_PH) begin
                    phase_nx = '0;
                    done_nx  = 1'b1;
                    fill_nx  = '0;
                    state_nx = S_FILL;
`ifdef WL_PREFETCH_EN
                    wbuf_nx = sbuf_nx;
                    if (sfill_nx == FULL) begin
                        cmp_nx   = slen_nx;
                        state_nx = S_BURST;
                    end else begin
                        fill_nx = sfill_nx;
                    end
                    sfill_nx = '0;
`endif
                end else begin
                    phase_nx = phase_q + PH_W'(1);
                end
            end
            default: state_nx = S_FILL;
        endcase
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FILL;
            phase_q <= '0;
            fill_q  <= '0;
            cmp_q   <= '0;
            done_q  <= 1'b0;
`ifdef WL_PREFETCH_EN
            sfill_q <= '0;
            slen_q  <= '0;
`endif
        end else begin
            state_q <= state_nx;
            phase_q <= phase_nx;
            fill_q  <= fill_nx;
            cmp_q   <= cmp_nx;
            done_q  <= done_nx;
`ifdef WL_PREFETCH_EN
            sfill_q <= sfill_nx;
            slen_q  <= slen_nx;
`endif
        end
    end

    // Weight storage needs no reset; fill counts gate every read.
    always_ff @(posedge clk) begin
        wbuf_q <= wbuf_nx;
`ifdef WL_PREFETCH_EN
        sbuf_q <= sbuf_nx;
`endif
    end

endmodule

// File: tb/tb_bfp16_ws_weight_loader.sv
// Bench for bfp16_ws_weight_loader: schedule-based reference model checked every cycle, plus directed literal checks.
module tb_bfp16_ws_weight_loader;
    localparam int unsigned ROWS  = 4;
    localparam int unsigned CNT_W = 16;
    localparam int KB = 0;
    localparam int KC = 1;
    localparam int KD = 2;

    typedef struct {
        int          kind;
        logic [15:0] din;
    } rec_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             w_valid = 1'b0;
    logic             w_ready;
    logic [15:0]      w_data = 16'h0000;
    logic [CNT_W-1:0] cmp_len = '0;
    logic             pe_ctrl;
    logic [15:0]      pe_in;
    logic             ifmap_en;
    logic             busy;
    logic             done;

    bfp16_ws_weight_loader #(.ROWS(ROWS), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .cmp_len(cmp_len), .pe_ctrl(pe_ctrl), .pe_in(pe_in), .ifmap_en(ifmap_en),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Model: a queue of per-cycle expected column activity plus collected words.
    rec_t             sched[$];
    logic [15:0]      words[$];
    logic [CNT_W-1:0] set_len;
    bit               done_pend;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_acc = 0;
    int last_done = -1;
    int ifm_cnt = 0;
    logic done_busy = 1'b0;
    logic [15:0] burst_log[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
        end
    endtask

    task automatic tick(input logic v, input logic [15:0] d, input logic [CNT_W-1:0] l, input logic r);
        logic        e_ctrl, e_ifm, e_rdy, e_busy, e_done;
        logic [15:0] e_in;
        bit          hs;
        @(negedge clk);
        cyc++;
        if (sched.size() != 0) begin
            e_ctrl = (sched[0].kind != KB);
            e_in   = sched[0].din;
            e_ifm  = (sched[0].kind == KC);
            e_rdy  = 1'b0;
`ifdef WL_PREFETCH_EN
            e_rdy  = (sched[0].kind != KB) && (words.size() < ROWS);
`endif
        end else begin
            e_ctrl = 1'b0;
            e_in   = 16'h0000;
            e_ifm  = 1'b0;
            e_rdy  = 1'b1;
        end
        e_busy = (sched.size() != 0) || (words.size() != 0);
        e_done = done_pend;
        chk("w_ready", 32'(w_ready), 32'(e_rdy));
        chk("pe_ctrl", 32'(pe_ctrl), 32'(e_ctrl));
        chk("pe_in", 32'(pe_in), 32'(e_in));
        chk("ifmap_en", 32'(ifmap_en), 32'(e_ifm));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("done", 32'(done), 32'(e_done));
        if (done === 1'b1) begin
            last_done = cyc;
            done_busy = busy;
        end
        if (ifmap_en === 1'b1) ifm_cnt++;
        if (busy === 1'b1 && pe_ctrl === 1'b0 && w_ready === 1'b0) burst_log.push_back(pe_in);

        rst = r; w_valid = v; w_data = d; cmp_len = l;
        hs = v && e_rdy && !r;
        if (r) begin
            sched.delete();
            words.delete();
            done_pend = 0;
        end else begin
            done_pend = 0;
            if (sched.size() != 0) begin
                sched.delete(0);
                if (sched.size() == 0) done_pend = 1;
            end
            if (hs) begin
                words.push_back(d);
                last_acc = cyc;
                if (words.size() == ROWS) set_len = l;
            end
            if (sched.size() == 0 && words.size() == ROWS) begin
                for (int k = 0; k < ROWS; k++) sched.push_back('{kind: KB, din: words[ROWS-1-k]});
                for (int k = 0; k < int'(set_len); k++) sched.push_back('{kind: KC, din: 16'h0000});
                for (int k = 0; k < ROWS; k++) sched.push_back('{kind: KD, din: 16'h0000});
                words.delete();
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 16'h0000, '0, 1'b0);
    endtask

    task automatic load(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2,
                        input logic [15:0] w3, input logic [CNT_W-1:0] l, input int gap);
        logic [15:0] ws[4];
        ws = '{w0, w1, w2, w3};
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, ws[i], l, 1'b0);
            if (i != 3) idle(gap);
        end
    endtask

    task automatic run_idle(input int limit);
        int n = 0;
        while ((sched.size() != 0 || done_pend) && n < limit) begin
            idle(1);
            n++;
        end
        chk("run_timeout", 32'(n < limit), 32'd1);
    endtask

    task automatic chk_burst(input logic [15:0] b0, input logic [15:0] b1,
                             input logic [15:0] b2, input logic [15:0] b3);
        logic [15:0] bs[4];
        bs = '{b0, b1, b2, b3};
        chk("burst_len", 32'(burst_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < burst_log.size()) chk("burst_word", 32'(burst_log[i]), 32'(bs[i]));
        end
    endtask

    initial begin
        sched.delete(); words.delete(); done_pend = 0; set_len = '0;
        repeat (2) @(posedge clk);
        rst = 1'b0;

        // Idle after reset.
        idle(10);
        chk("idle_no_done", 32'(last_done), 32'hFFFF_FFFF);

        // Back-to-back load, len 5.
        burst_log.delete(); ifm_cnt = 0;
        load(16'h3F80, 16'h4000, 16'h4040, 16'h4080, 16'd5, 0);
        run_idle(100);
        chk("done_lat_len5", 32'(last_done - last_acc), 32'd14);
        chk("ifm_cnt_len5", 32'(ifm_cnt), 32'd5);
        chk_burst(16'h4080, 16'h4040, 16'h4000, 16'h3F80);

        // Gapped load gives the same burst.
        burst_log.delete(); ifm_cnt = 0;
        load(16'h3F80, 16'h4000, 16'h4040, 16'h4080, 16'd5, 2);
        run_idle(100);
        chk("done_lat_gap", 32'(last_done - last_acc), 32'd14);
        chk_burst(16'h4080, 16'h4040, 16'h4000, 16'h3F80);

        // Zero compute length.
        burst_log.delete(); ifm_cnt = 0;
        load(16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'd0, 0);
        run_idle(100);
        chk("done_lat_len0", 32'(last_done - last_acc), 32'd9);
        chk("ifm_cnt_len0", 32'(ifm_cnt), 32'd0);

        // Reset in compute cycle 2, then a fresh set.
        load(16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D, 16'd5, 0);
        idle(5);
        last_done = -1;
        tick(1'b0, 16'h0000, '0, 1'b1);
        idle(6);
        chk("rst_no_done", 32'(last_done), 32'hFFFF_FFFF);
        burst_log.delete();
        load(16'hA001, 16'hA002, 16'hA003, 16'hA004, 16'd1, 0);
        run_idle(100);
        chk_burst(16'hA004, 16'hA003, 16'hA002, 16'hA001);

`ifdef WL_PREFETCH_EN
        // Second set loaded during compute bursts right after done.
        load(16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'd8, 0);
        idle(6);
        load(16'h0B01, 16'h0B02, 16'h0B03, 16'h0B04, 16'd2, 0);
        burst_log.delete(); done_busy = 1'b0;
        run_idle(100);
        chk("pf_done_busy", 32'(done_busy), 32'd1);
        chk_burst(16'h0B04, 16'h0B03, 16'h0B02, 16'h0B01);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            tick(1'($urandom_range(0, 1)), 16'($urandom), CNT_W'($urandom_range(0, 6)),
                 ($urandom_range(0, 299) == 0));
        end
        tick(1'b0, 16'h0000, '0, 1'b0);
        run_idle(200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
